// File: rtl/eeprom_req_seq_pkg.sv
// Shared constants for the EEPROM request sequencer.
//   - Engine command codes driven on start_sig.
//   - FSM state encodings (3-bit, legacy-compatible localparams).
//   - Default tWR / timeout cycle counts for a 50 MHz sysclk.
package eeprom_req_seq_pkg;

  // Engine command codes
  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_RD   = 2'b10;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_TWR  = 3'd2;
  localparam logic [2:0] ST_RESP = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  // 5 ms write-cycle time and 50 ms engine timeout at 50 MHz
  localparam int unsigned TWR_CYCLES_DEF = 250000;
  localparam int unsigned TO_CYCLES_DEF  = 2500000;
  localparam int          CNT_W_DEF      = 22;

endpackage

// File: rtl/eeprom_req_seq.sv
// Request sequencer in front of the I2C byte engine (iic_com) on the
// AT24C EEPROM path. Takes single-byte read/write requests, holds the
// engine's level start_sig until done_sig, waits out tWR after writes,
// and returns a one-cycle response per request.
//
// Handshake: a request transfers on the rising sysclk edge where
// req_valid && req_ready are both high; req_ready is high only while idle,
// and the request inputs are ignored at every other time.
//
// Ports:
//   sysclk, rst_n           clock, async active-low reset
//   req_valid/req_ready     request handshake
//   req_we/addr/wdata       request payload
//   rsp_valid/we/rdata      one-cycle response pulse + payload
//   err                     sticky timeout flag, cleared on next accept
//   start_sig/addr_sig/wrdata  command to engine
//   rddata/done_sig         result from engine
//   dbg_state               current FSM state
module eeprom_req_seq
  import eeprom_req_seq_pkg::*;
#(
  parameter int unsigned TWR_CYCLES = TWR_CYCLES_DEF,
  parameter int unsigned TO_CYCLES  = TO_CYCLES_DEF,
  parameter int          CNT_W      = CNT_W_DEF
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic       rsp_we,
  output logic [7:0] rsp_rdata,
  output logic       err,
  output logic [1:0] start_sig,
  output logic [7:0] addr_sig,
  output logic [7:0] wrdata,
  input  logic [7:0] rddata,
  input  logic       done_sig,
  output logic [2:0] dbg_state
);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYCLES - 1);
  localparam logic [CNT_W-1:0] TWR_LAST = CNT_W'(TWR_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [1:0]       start_q, start_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_we_q, rsp_we_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    start_d = start_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        // ready_q (not the state) gates acceptance so nothing is taken
        // in the first cycle after reset release.
        if (req_valid && ready_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = 1'b0;
          cnt_d   = '0;
          start_d = req_we ? CMD_WR : CMD_RD;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (done_sig) begin
          start_d = CMD_IDLE;
          rdata_d = we_q ? 8'h00 : rddata;
          cnt_d   = '0;
          state_d = we_q ? ST_TWR : ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          // Engine cannot be aborted mid-byte: keep start held, flag the
          // timeout and let the counter saturate.
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_TWR: begin
        if (cnt_q == TWR_LAST) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs follow the next state so they line up with it.
    ready_d     = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    rsp_we_d    = (state_d == ST_RESP) && we_q;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      start_q     <= CMD_IDLE;
      rdata_q     <= 8'h00;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      start_q     <= start_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rdata_q;
  assign err       = err_q;
  assign start_sig = start_q;
  assign addr_sig  = addr_q;
  assign wrdata    = wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_eeprom_req_seq.sv
// Self-checking bench for eeprom_req_seq with a behavioural engine model
// (TWR_CYCLES=100, TO_CYCLES=1000). Table-driven transactions plus
// hand-written back-to-back, timeout, reset and spurious-done sequences.
module tb_eeprom_req_seq;
  import eeprom_req_seq_pkg::*;

  localparam int TWR = 100;
  localparam int TO  = 1000;

  // ---------------- clock / reset ----------------
  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       req_ready, rsp_valid, rsp_we, err;
  logic [7:0] rsp_rdata, addr_sig, wrdata, rddata;
  logic [1:0] start_sig;
  logic       done_sig;
  logic [2:0] dbg_state;

  always #5 sysclk = ~sysclk;

  eeprom_req_seq #(.TWR_CYCLES(TWR), .TO_CYCLES(TO), .CNT_W(22)) dut (
    .sysclk(sysclk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata), .err(err),
    .start_sig(start_sig), .addr_sig(addr_sig), .wrdata(wrdata),
    .rddata(rddata), .done_sig(done_sig), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;

  always @(negedge sysclk) if (rsp_valid === 1'b1) rsp_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         delay;     // CMD cycle in which the engine pulses done
    logic [7:0] rd;        // byte the engine returns
    int         spur;      // TWR cycle with a stray done pulse (0 = none)
    logic [1:0] exp_start;
    logic [7:0] exp_rdata;
    int         exp_lat;   // cycles from done cycle to rsp_valid cycle
  } vec_t;

  vec_t vecs[5];

  task automatic set_vec(input int i, input logic we, input logic [7:0] a, input logic [7:0] d,
                         input int dly, input logic [7:0] rd, input int spur,
                         input logic [1:0] es, input logic [7:0] er, input int lat);
    vecs[i].we = we; vecs[i].addr = a; vecs[i].wdata = d; vecs[i].delay = dly;
    vecs[i].rd = rd; vecs[i].spur = spur; vecs[i].exp_start = es;
    vecs[i].exp_rdata = er; vecs[i].exp_lat = lat;
  endtask

  // ---------------- driver tasks ----------------
  task automatic handshake(input logic we, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin tick(); n++; end
    check("hs_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    tick();
    // Scramble inputs: they must be ignored outside the handshake.
    req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~d;
  endtask

  task automatic run_vec(input vec_t v);
    int bad = 0;
    int lat;
    handshake(v.we, v.addr, v.wdata);
    check("cmd_start", {30'd0, start_sig}, {30'd0, v.exp_start});
    check("cmd_addr", {24'd0, addr_sig}, {24'd0, v.addr});
    check("cmd_wdata", {24'd0, wrdata}, {24'd0, v.wdata});
    check("cmd_ready", {31'd0, req_ready}, 32'd0);
    for (int k = 1; k < v.delay; k++) begin
      tick();
      if (start_sig !== v.exp_start || addr_sig !== v.addr || wrdata !== v.wdata) bad++;
    end
    check("cmd_hold", bad, 0);
    rddata = v.rd; done_sig = 1'b1;
    tick();
    done_sig = 1'b0; rddata = 8'hEE;
    check("done_start", {30'd0, start_sig}, 32'd0);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 400) begin
      if (v.spur != 0 && lat == v.spur) done_sig = 1'b1;
      tick();
      done_sig = 1'b0;
      lat++;
    end
    check("rsp_lat", lat, v.exp_lat);
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsp_we", {31'd0, rsp_we}, {31'd0, v.we});
    check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, v.exp_rdata});
    check("rsp_err", {31'd0, err}, 32'd0);
    check("rsp_ready", {31'd0, req_ready}, 32'd0);
    tick();
    check("gap_valid", {31'd0, rsp_valid}, 32'd0);
    check("gap_ready", {31'd0, req_ready}, 32'd0);
    tick();
    check("idle_ready", {31'd0, req_ready}, 32'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    int n;
    int zeros;
    int cnt0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00;
    req_wdata = 8'h00; rddata = 8'h00; done_sig = 1'b0;

    set_vec(0, 1'b1, 8'h10, 8'hA5, 300, 8'h77, 0,  CMD_WR, 8'h00, TWR + 1);
    set_vec(1, 1'b0, 8'h10, 8'h00, 20,  8'h3C, 0,  CMD_RD, 8'h3C, 1);
    set_vec(2, 1'b1, 8'hFF, 8'h5A, 1,   8'h66, 10, CMD_WR, 8'h00, TWR + 1);
    set_vec(3, 1'b0, 8'h00, 8'h00, 1,   8'hC3, 0,  CMD_RD, 8'hC3, 1);
    set_vec(4, 1'b0, 8'hFF, 8'h12, 7,   8'h81, 0,  CMD_RD, 8'h81, 1);

    // Reset state
    repeat (3) @(posedge sysclk);
    #1;
    check("rst_outs", {12'd0, req_ready, rsp_valid, rsp_we, err, start_sig, rsp_rdata, addr_sig, wrdata}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    rst_n = 1'b1;
    tick();
    check("rel_ready", {31'd0, req_ready}, 32'd1);

    // Spurious done in IDLE
    done_sig = 1'b1;
    tick();
    done_sig = 1'b0;
    check("spur_idle_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("spur_idle_out", {28'd0, rsp_valid, req_ready, start_sig}, {28'd0, 1'b0, 1'b1, CMD_IDLE});

    // Table-driven transactions
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Back-to-back reads with req_valid held high
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h20; req_wdata = 8'h00;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    check("b2b_cmd1", {30'd0, start_sig}, {30'd0, CMD_RD});
    repeat (4) tick();
    rddata = 8'h11; done_sig = 1'b1;
    tick();
    done_sig = 1'b0;
    check("b2b_rsp1", {31'd0, rsp_valid}, 32'd1);
    check("b2b_rsp1_ready", {31'd0, req_ready}, 32'd0);
    check("b2b_rsp1_data", {24'd0, rsp_rdata}, 32'h11);
    zeros = 1;
    n = 0;
    while (start_sig === CMD_IDLE && n < 10) begin
      tick(); n++;
      if (start_sig === CMD_IDLE) zeros++;
    end
    check("b2b_gap", zeros, 3);
    check("b2b_cmd2", {30'd0, start_sig}, {30'd0, CMD_RD});
    req_valid = 1'b0;
    repeat (3) tick();
    rddata = 8'h22; done_sig = 1'b1;
    tick();
    done_sig = 1'b0;
    check("b2b_rsp2", {24'd0, rsp_rdata}, 32'h22);
    repeat (2) tick();

    // Timeout: engine never answers, late done at cycle 1500
    handshake(1'b0, 8'h30, 8'h00);
    n = 0;
    while (err !== 1'b1 && n < 1200) begin tick(); n++; end
    check("to_cycle", n, TO);
    check("to_start", {30'd0, start_sig}, {30'd0, CMD_RD});
    repeat (1500 - TO - 1) tick();
    check("to_hold", {29'd0, err, start_sig}, {29'd0, 1'b1, CMD_RD});
    check("to_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rddata = 8'h99; done_sig = 1'b1;
    tick();
    done_sig = 1'b0;
    check("late_rsp", {22'd0, rsp_valid, err, rsp_rdata}, {22'd0, 1'b1, 1'b1, 8'h99});
    repeat (2) tick();
    handshake(1'b1, 8'h40, 8'h55);
    check("err_clear", {31'd0, err}, 32'd0);

    // Reset during TWR (cycle 50)
    tick();
    done_sig = 1'b1;
    tick();
    done_sig = 1'b0;
    repeat (49) tick();
    check("twr_state", {29'd0, dbg_state}, {29'd0, ST_TWR});
    cnt0 = rsp_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {12'd0, req_ready, rsp_valid, rsp_we, err, start_sig, rsp_rdata, addr_sig, wrdata}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("mid_rel_ready", {31'd0, req_ready}, 32'd1);
    repeat (150) tick();
    check("mid_no_rsp", rsp_cnt - cnt0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
